// File: rtl/l1_cache_ctrl_if.sv
// CPU load/store port and block-memory port of the L1 cache controller.
// slave = cache side, master = CPU/memory environment side.
`ifndef Memory_Block_Size
`define Memory_Block_Size 128
`endif

interface l1_cache_ctrl_if;
    logic                          cpu_req;
    logic                          cpu_wr;
    logic [11:0]                   cpu_addr;
    logic [31:0]                   cpu_wdata;
    logic [31:0]                   cpu_rdata;
    logic                          cpu_ready;
    logic                          mem_Req_Low;
    logic [9:0]                    mem_addr;
    logic [`Memory_Block_Size-1:0] mem_din;
    logic                          mem_Wr;
    logic [`Memory_Block_Size-1:0] mem_dout;
    logic                          mem_Rdy_Low;

    modport slave (
        input  cpu_req, cpu_wr, cpu_addr, cpu_wdata, mem_dout, mem_Rdy_Low,
        output cpu_rdata, cpu_ready, mem_Req_Low, mem_addr, mem_din, mem_Wr
    );

    modport master (
        output cpu_req, cpu_wr, cpu_addr, cpu_wdata, mem_dout, mem_Rdy_Low,
        input  cpu_rdata, cpu_ready, mem_Req_Low, mem_addr, mem_din, mem_Wr
    );
endinterface

// File: rtl/l1_cache_ctrl.sv
// Direct-mapped write-back/write-allocate L1 cache; CACHE_STATS_EN adds hit/miss counters.
// Latency: hit 2 cycles req->ready; a miss adds a refill (plus victim write-back if dirty).
// Backpressure: one access in flight; cpu_req is only sampled in IDLE, memory held until Rdy_Low + MEM_EXTRA_WAIT.
`ifndef Memory_Block_Size
`define Memory_Block_Size 128
`endif

module l1_cache_ctrl #(
    parameter int INDEX_BITS     = 4,
    parameter int MEM_EXTRA_WAIT = 1
) (
    input  logic clk,
    input  logic rst,
    l1_cache_ctrl_if.slave bus
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt
`endif
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 10 - INDEX_BITS;
    localparam int BW    = `Memory_Block_Size;
    localparam int CNT_W = (MEM_EXTRA_WAIT < 1) ? 1 : $clog2(MEM_EXTRA_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST =
        (MEM_EXTRA_WAIT == 0) ? '0 : CNT_W'(MEM_EXTRA_WAIT - 1);

    typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;

    state_t            state_q;
    logic              wr_q;
    logic [11:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [LINES-1:0]  valid_q;
    logic [LINES-1:0]  dirty_q;
    logic [TAG_W-1:0]  tag_arr_q  [LINES];
    logic [BW-1:0]     data_arr_q [LINES];
    logic              cpu_ready_q;
    logic [31:0]       cpu_rdata_q;
    logic              req_low_q;
    logic              mem_wr_q;
    logic [9:0]        mem_addr_q;
    logic [BW-1:0]     mem_din_q;
    logic [CNT_W-1:0]  wait_cnt_q;
    logic              rdy_seen_q;

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_W-1:0]      tag;
    logic [1:0]            word;
    logic                  hit;
    logic                  in_xfer;
    logic                  xfer_done;
    logic                  line_we;
    logic                  tag_we;
    logic [BW-1:0]         line_d;

    assign idx     = addr_q[2 +: INDEX_BITS];
    assign tag     = addr_q[11 -: TAG_W];
    assign word    = addr_q[1:0];
    assign hit     = valid_q[idx] && (tag_arr_q[idx] == tag);
    assign in_xfer = !req_low_q && ((state_q == WRITEBACK) || (state_q == ALLOCATE));
    // Last held cycle: either the extra-wait count ran out, or no extra wait at all.
    assign xfer_done = in_xfer &&
        (rdy_seen_q ? (wait_cnt_q == CNT_LAST) : (!bus.mem_Rdy_Low && (MEM_EXTRA_WAIT == 0)));

    always_comb begin
        line_d  = data_arr_q[idx];
        line_we = 1'b0;
        tag_we  = 1'b0;
        if (state_q == ALLOCATE && xfer_done) begin
            line_d  = bus.mem_dout;
            line_we = 1'b1;
            tag_we  = 1'b1;
        end else if (state_q == COMPARE && hit && wr_q) begin
            line_d[{word, 5'b0} +: 32] = wdata_q;
            line_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (line_we) data_arr_q[idx] <= line_d;
        if (tag_we)  tag_arr_q[idx]  <= tag;
    end

`ifdef CACHE_STATS_EN
    logic        retry_q;
    logic [15:0] hit_cnt_q;
    logic [15:0] miss_cnt_q;
    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            valid_q     <= '0;
            dirty_q     <= '0;
            cpu_ready_q <= 1'b0;
            cpu_rdata_q <= '0;
            req_low_q   <= 1'b1;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            wait_cnt_q  <= '0;
            rdy_seen_q  <= 1'b0;
`ifdef CACHE_STATS_EN
            retry_q     <= 1'b0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
`endif
        end else begin
            cpu_ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.cpu_req) begin
                        wr_q    <= bus.cpu_wr;
                        addr_q  <= bus.cpu_addr;
                        wdata_q <= bus.cpu_wdata;
                        state_q <= COMPARE;
`ifdef CACHE_STATS_EN
                        retry_q <= 1'b0;
`endif
                    end
                end
                COMPARE: begin
`ifdef CACHE_STATS_EN
                    if (!retry_q) begin
                        if (hit && hit_cnt_q != 16'hFFFF)   hit_cnt_q  <= hit_cnt_q + 16'd1;
                        if (!hit && miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
                    end
`endif
                    if (hit) begin
                        cpu_ready_q <= 1'b1;
                        if (wr_q) dirty_q[idx] <= 1'b1;
                        else      cpu_rdata_q  <= data_arr_q[idx][{word, 5'b0} +: 32];
                        state_q <= IDLE;
                    end else if (valid_q[idx] && dirty_q[idx]) begin
                        state_q <= WRITEBACK;
                    end else begin
                        state_q <= ALLOCATE;
                    end
                end
                WRITEBACK: begin
                    if (req_low_q) begin
                        req_low_q  <= 1'b0;
                        mem_wr_q   <= 1'b1;
                        mem_addr_q <= {tag_arr_q[idx], idx};
                        mem_din_q  <= data_arr_q[idx];
                        wait_cnt_q <= '0;
                        rdy_seen_q <= 1'b0;
                    end else if (xfer_done) begin
                        // Releasing here leaves Req_Low high for a cycle before the refill starts.
                        req_low_q    <= 1'b1;
                        mem_wr_q     <= 1'b0;
                        dirty_q[idx] <= 1'b0;
                        state_q      <= ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    if (req_low_q) begin
                        req_low_q  <= 1'b0;
                        mem_wr_q   <= 1'b0;
                        mem_addr_q <= addr_q[11:2];
                        wait_cnt_q <= '0;
                        rdy_seen_q <= 1'b0;
                    end else if (xfer_done) begin
                        req_low_q    <= 1'b1;
                        valid_q[idx] <= 1'b1;
                        dirty_q[idx] <= 1'b0;
                        state_q      <= COMPARE;
`ifdef CACHE_STATS_EN
                        retry_q      <= 1'b1;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (in_xfer && !xfer_done) begin
                if (!rdy_seen_q) begin
                    if (!bus.mem_Rdy_Low) rdy_seen_q <= 1'b1;
                end else begin
                    wait_cnt_q <= wait_cnt_q + 1'b1;
                end
            end
        end
    end

    assign bus.cpu_ready   = cpu_ready_q;
    assign bus.cpu_rdata   = cpu_rdata_q;
    assign bus.mem_Req_Low = req_low_q;
    assign bus.mem_Wr      = mem_wr_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_din     = mem_din_q;
endmodule

// File: tb/tb_l1_cache_ctrl.sv
// Random load/store traffic against a flat-memory reference; a monitor scores CPU replies and memory transactions.
module tb_l1_cache_ctrl;
    localparam int IB    = 4;
    localparam int W     = 1;
    localparam int LINES = 1 << IB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    l1_cache_ctrl_if bus();
`ifdef CACHE_STATS_EN
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
`endif

    l1_cache_ctrl #(.INDEX_BITS(IB), .MEM_EXTRA_WAIT(W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef CACHE_STATS_EN
        ,
        .hit_cnt(hit_cnt),
        .miss_cnt(miss_cnt)
`endif
    );

    typedef struct { logic wr; logic [9:0] addr; logic [127:0] din; } mexp_t;
    typedef struct { logic wr; logic [31:0] data; logic hit; int cyc; } cexp_t;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int resp_cnt = 0;
    int force_dly = -1;
    int m_hits = 0;
    int m_miss = 0;

    logic [127:0] mem      [1024];
    logic [31:0]  ref_word [4096];
    logic         m_valid  [LINES];
    logic         m_dirty  [LINES];
    logic [5:0]   m_tag    [LINES];
    logic [31:0]  m_last;
    mexp_t        mem_q[$];
    cexp_t        cpu_q[$];

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int b, input int w);
        return 32'h5A000000 ^ (32'(b) << 8) ^ 32'(w * 17);
    endfunction

    function automatic logic [127:0] block_of(input logic [9:0] b);
        logic [127:0] r;
        for (int w = 0; w < 4; w++) r[w*32 +: 32] = ref_word[int'(b) * 4 + w];
        return r;
    endfunction

    // Cache contents are lost on reset; the coherent view falls back to the backing memory.
    task automatic model_reset();
        for (int i = 0; i < LINES; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = '0;
        end
        for (int b = 0; b < 1024; b++)
            for (int w = 0; w < 4; w++) ref_word[b*4 + w] = mem[b][w*32 +: 32];
        m_last = '0;
        m_hits = 0;
        m_miss = 0;
    endtask

    task automatic predict(input logic wr, input logic [11:0] addr, input logic [31:0] wdata);
        logic [IB-1:0] idx;
        logic [5:0]    tag;
        logic          hit;
        logic [9:0]    vb;
        idx = addr[5:2];
        tag = addr[11:6];
        hit = m_valid[idx] && (m_tag[idx] == tag);
        if (hit) m_hits++; else m_miss++;
        if (!hit) begin
            if (m_valid[idx] && m_dirty[idx]) begin
                vb = {m_tag[idx], idx};
                mem_q.push_back('{1'b1, vb, block_of(vb)});
            end
            mem_q.push_back('{1'b0, addr[11:2], 128'd0});
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tag;
            m_dirty[idx] = 1'b0;
        end
        if (wr) begin
            ref_word[addr] = wdata;
            m_dirty[idx]   = 1'b1;
            cpu_q.push_back('{1'b1, m_last, hit, cyc});
        end else begin
            m_last = ref_word[addr];
            cpu_q.push_back('{1'b0, m_last, hit, cyc});
        end
    endtask

    task automatic access(input logic wr, input logic [11:0] addr, input logic [31:0] wdata);
        int start;
        int t;
        start = resp_cnt;
        predict(wr, addr, wdata);
        bus.cpu_req   = 1'b1;
        bus.cpu_wr    = wr;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        @(negedge clk);
        bus.cpu_req = 1'b0;
        t = 0;
        while (resp_cnt == start && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("access_timeout", 128'(resp_cnt != start), 128'd1);
    endtask

    // Block memory: acknowledges each request after 0..3 cycles, writes on acknowledge.
    logic busy = 1'b0;
    int   dly  = 0;
    always @(negedge clk) begin
        if (rst) begin
            bus.mem_Rdy_Low = 1'b1;
            busy = 1'b0;
        end else if (!bus.mem_Req_Low) begin
            if (!busy) begin
                busy = 1'b1;
                dly  = (force_dly >= 0) ? force_dly : int'($urandom_range(0, 3));
            end
            if (bus.mem_Rdy_Low) begin
                if (dly == 0) begin
                    bus.mem_Rdy_Low = 1'b0;
                    if (bus.mem_Wr) mem[bus.mem_addr] = bus.mem_din;
                end else begin
                    dly--;
                end
            end
        end else begin
            bus.mem_Rdy_Low = 1'b1;
            busy = 1'b0;
        end
        bus.mem_dout = mem[bus.mem_addr];
    end

    logic         prev_req = 1'b1;
    logic         prev_ready = 1'b0;
    logic         seen = 1'b0;
    logic         stable_ok = 1'b1;
    int           held = 0;
    logic [9:0]   rec_addr;
    logic         rec_wr;
    logic [127:0] rec_din;
    always @(negedge clk) begin
        mexp_t me;
        cexp_t ce;
        #2;
        if (rst) begin
            prev_req   = 1'b1;
            prev_ready = 1'b0;
            seen       = 1'b0;
        end else begin
            check("wr_while_req_high", 128'(bus.mem_Req_Low & bus.mem_Wr), 128'd0);
            if (prev_req && !bus.mem_Req_Low) begin
                if (mem_q.size() == 0) begin
                    check("unexpected_mem_req", 128'(bus.mem_addr), 128'h3FF_FFFF);
                end else begin
                    me = mem_q.pop_front();
                    check("mem_wr", 128'(bus.mem_Wr), 128'(me.wr));
                    check("mem_addr", 128'(bus.mem_addr), 128'(me.addr));
                    if (me.wr) check("writeback_din", bus.mem_din, me.din);
                end
                rec_addr = bus.mem_addr;
                rec_wr = bus.mem_Wr;
                rec_din = bus.mem_din;
                seen = 1'b0;
                held = 0;
                stable_ok = 1'b1;
            end
            if (!bus.mem_Req_Low) begin
                if (seen) held++;
                else if (!bus.mem_Rdy_Low) begin
                    seen = 1'b1;
                    held = 0;
                end
                if (bus.mem_addr != rec_addr || bus.mem_Wr != rec_wr || bus.mem_din != rec_din)
                    stable_ok = 1'b0;
            end
            if (!prev_req && bus.mem_Req_Low) begin
                check("hold_after_rdy", 128'(held), 128'(W));
                check("held_stable", 128'(stable_ok), 128'd1);
            end
            prev_req = bus.mem_Req_Low;

            if (bus.cpu_ready) begin
                check("ready_pulse_width", 128'(prev_ready), 128'd0);
                if (!prev_ready) begin
                    if (cpu_q.size() == 0) begin
                        check("unexpected_ready", 128'(bus.cpu_rdata), 128'h1_0000_0000);
                    end else begin
                        ce = cpu_q.pop_front();
                        check(ce.wr ? "store_rdata_hold" : "load_rdata", 128'(bus.cpu_rdata), 128'(ce.data));
                        if (ce.hit) check("hit_latency", 128'(cyc - ce.cyc), 128'd2);
                    end
                    resp_cnt++;
                end
            end
            prev_ready = bus.cpu_ready;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int t;
        bus.cpu_req   = 1'b0;
        bus.cpu_wr    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        for (int b = 0; b < 1024; b++)
            for (int w = 0; w < 4; w++) mem[b][w*32 +: 32] = pat(b, w);
        model_reset();

        repeat (3) @(negedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        check("rst_cpu_ready", 128'(bus.cpu_ready), 128'd0);
        check("rst_cpu_rdata", 128'(bus.cpu_rdata), 128'd0);
        check("rst_req_low", 128'(bus.mem_Req_Low), 128'd1);
        check("rst_mem_wr", 128'(bus.mem_Wr), 128'd0);
        check("rst_mem_addr", 128'(bus.mem_addr), 128'd0);
        check("rst_mem_din", bus.mem_din, 128'd0);

        access(1'b0, 12'h004, 32'h0);
        access(1'b1, 12'h005, 32'hDEADBEEF);
        access(1'b0, 12'h005, 32'h0);
        access(1'b0, 12'h045, 32'h0);

        force_dly = 3;
        access(1'b0, 12'h300, 32'h0);
        access(1'b1, 12'h7C1, 32'h12345678);
        access(1'b0, 12'h001, 32'h0);
        force_dly = -1;

        // Reset while a refill is outstanding.
        predict(1'b0, 12'h104, 32'h0);
        bus.cpu_req  = 1'b1;
        bus.cpu_wr   = 1'b0;
        bus.cpu_addr = 12'h104;
        @(negedge clk);
        bus.cpu_req = 1'b0;
        t = 0;
        while (bus.mem_Req_Low && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("alloc_started", 128'(bus.mem_Req_Low), 128'd0);
        #3 rst = 1'b1;
        #1;
        check("midrst_req_low", 128'(bus.mem_Req_Low), 128'd1);
        check("midrst_mem_wr", 128'(bus.mem_Wr), 128'd0);
        check("midrst_cpu_ready", 128'(bus.cpu_ready), 128'd0);
        cpu_q.delete();
        mem_q.delete();
        model_reset();
        @(negedge clk);
        #3 rst = 1'b0;
        @(negedge clk);

        access(1'b0, 12'h104, 32'h0);
        check("refetch_after_rst", 128'(mem_q.size()), 128'd0);
        access(1'b0, 12'h105, 32'h0);
        access(1'b1, 12'h106, 32'hCAFEF00D);
`ifdef CACHE_STATS_EN
        check("stats_hit", 128'(hit_cnt), 128'd2);
        check("stats_miss", 128'(miss_cnt), 128'd1);
`endif

        for (int i = 0; i < 400; i++) begin
            logic [11:0] a;
            a = {4'(0), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 7) == 0) a[11:10] = 2'($urandom_range(1, 3));
            access(1'($urandom_range(0, 1)), a, $urandom);
        end

        repeat (5) @(negedge clk);
        check("cpu_queue_empty", 128'(cpu_q.size()), 128'd0);
        check("mem_queue_empty", 128'(mem_q.size()), 128'd0);
`ifdef CACHE_STATS_EN
        check("final_hit_cnt", 128'(hit_cnt), 128'(m_hits));
        check("final_miss_cnt", 128'(miss_cnt), 128'(m_miss));
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
